// File: rtl/axi_sram_slave_pkg.sv
// Shared definitions for the single-beat AXI3 SRAM slave: response codes,
// channel FSM encodings and the byte-lane merge helper.
package axi_sram_slave_pkg;

  localparam int ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_RESP
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_COLLECT,
    WR_WAIT,
    WR_RESP
  } wr_state_e;

  // Lanes with a set strobe take the new byte, the rest keep the old one.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_sram_slave_ram.sv
// Word-wide RAM with one byte-enabled synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module axi_sram_slave_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave in front of a word RAM. Independent read and write
// channel FSMs, one outstanding transaction each, programmable response latency.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int          MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h1c000000,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT_INIT = 4'(WR_LAT - 1);

  // Out-of-window addresses decode-error first; bad burst shape is a slave error.
  function automatic logic [1:0] addr_resp(input logic [29-MEM_AW:0] tag,
                                           input logic [7:0]         len,
                                           input logic [2:0]         size);
    if (tag != BASE_ADDR[31:MEM_AW+2]) return RESP_DECERR;
    if (len != 8'd0 || size > 3'd2) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic unused_inputs;
  assign unused_inputs = ^{arburst, arlock, arcache, arprot, awburst, awlock,
                           awcache, awprot, wid, wlast, araddr[1:0], awaddr[1:0]};

  rd_state_e         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [ID_W-1:0]   rd_id_q, rd_id_d;
  logic [1:0]        rd_resp_q, rd_resp_d;
  logic [MEM_AW-1:0] rd_idx_q, rd_idx_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;

  wr_state_e         wr_state_q, wr_state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              aw_have_q, aw_have_d;
  logic              w_have_q, w_have_d;
  logic [ID_W-1:0]   wr_id_q, wr_id_d;
  logic [MEM_AW-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]        wr_resp_q, wr_resp_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [3:0]        wr_cnt_q, wr_cnt_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic        wr_commit;
  logic [31:0] ram_rdata;
  logic [31:0] rd_sample;
  logic        aw_fire, w_fire;

  assign aw_fire = awvalid && awready_q;
  assign w_fire  = wvalid && wready_q;

  axi_sram_slave_ram #(.AW(MEM_AW)) u_ram (
    .clk  (aclk),
    .we   (wr_commit),
    .waddr(wr_idx_d),
    .wdata(wdata_d),
    .wstrb(wstrb_d),
    .raddr(rd_idx_q),
    .rdata(ram_rdata)
  );

  // A commit landing on the word being sampled this cycle is forwarded so the read sees the new data.
  assign rd_sample = (wr_commit && (wr_idx_d == rd_idx_q))
                     ? merge_bytes(ram_rdata, wdata_d, wstrb_d) : ram_rdata;

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_id_d    = rd_id_q;
    rd_resp_d  = rd_resp_q;
    rd_idx_d   = rd_idx_q;
    rd_cnt_d   = rd_cnt_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          rd_id_d    = arid;
          rd_idx_d   = araddr[MEM_AW+1:2];
          rd_resp_d  = addr_resp(araddr[31:MEM_AW+2], arlen, arsize);
          rd_cnt_d   = RD_CNT_INIT;
          arready_d  = 1'b0;
          rd_state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q == 4'd0) begin
          rvalid_d   = 1'b1;
          rlast_d    = 1'b1;
          rid_d      = rd_id_q;
          rresp_d    = rd_resp_q;
          rdata_d    = (rd_resp_q == RESP_OKAY) ? rd_sample : 32'd0;
          rd_state_d = RD_RESP;
        end else begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d   = 1'b0;
          rlast_d    = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // AW and W are taken independently; the cycle the second one arrives is the commit cycle.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_have_d  = aw_have_q;
    w_have_d   = w_have_q;
    wr_id_d    = wr_id_q;
    wr_idx_d   = wr_idx_q;
    wr_resp_d  = wr_resp_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_cnt_d   = wr_cnt_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    unique case (wr_state_q)
      WR_IDLE, WR_COLLECT: begin
        if (aw_fire) begin
          aw_have_d = 1'b1;
          wr_id_d   = awid;
          wr_idx_d  = awaddr[MEM_AW+1:2];
          wr_resp_d = addr_resp(awaddr[31:MEM_AW+2], awlen, awsize);
        end
        if (w_fire) begin
          w_have_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        awready_d = !aw_have_d;
        wready_d  = !w_have_d;
        if (aw_have_d && w_have_d) begin
          wr_commit  = (wr_resp_d == RESP_OKAY);
          aw_have_d  = 1'b0;
          w_have_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          wr_cnt_d   = WR_CNT_INIT;
          wr_state_d = WR_WAIT;
        end else if (aw_have_d || w_have_d) begin
          wr_state_d = WR_COLLECT;
        end
      end
      WR_WAIT: begin
        if (wr_cnt_q == 4'd0) begin
          bvalid_d   = 1'b1;
          bid_d      = wr_id_q;
          bresp_d    = wr_resp_q;
          wr_state_d = WR_RESP;
        end else begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rd_id_q    <= '0;
      rd_resp_q  <= '0;
      rd_idx_q   <= '0;
      rd_cnt_q   <= '0;
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      wr_id_q    <= '0;
      wr_idx_q   <= '0;
      wr_resp_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_cnt_q   <= '0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_id_q    <= rd_id_d;
      rd_resp_q  <= rd_resp_d;
      rd_idx_q   <= rd_idx_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_have_q  <= aw_have_d;
      w_have_q   <= w_have_d;
      wr_id_q    <= wr_id_d;
      wr_idx_q   <= wr_idx_d;
      wr_resp_q  <= wr_resp_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_cnt_q   <= wr_cnt_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus tasks queue expected responses,
// a negedge monitor pops and compares them at each R/B handshake.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;
  localparam int BUDGET = 50;

  logic        aclk, aresetn;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  rd_exp_t mon_rd;
  wr_exp_t mon_wr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ar_wait;

  axi_sram_slave #(
    .MEM_AW(14), .BASE_ADDR(32'h1c000000), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: event occurred or was missing", name);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_ctrl"}, 32'({arready, rvalid, rlast, rid, rresp,
                                      awready, wready, bvalid, bid, bresp}), 32'd0);
    check_output({tag, "_rdata"}, rdata, 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    aresetn = 1'b0;
    #1;
    check_idle_outputs(tag);
    repeat (2) @(posedge aclk);
    #1;
    check_idle_outputs({tag, "_held"});
    aresetn = 1'b1;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int hold);
    int waited;
    int acc_cyc;
    rd_q.push_back('{id: id, data: exp_data, resp: exp_resp});
    arid = id; araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
    waited = 0;
    while (!arready && waited < BUDGET) begin
      @(posedge aclk); #1; waited++;
    end
    if (!arready) begin
      fail_event("ar_accept_timeout");
      arvalid = 1'b0;
      void'(rd_q.pop_back());
      return;
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    acc_cyc = cyc;
    last_ar_wait = waited;
    waited = 0;
    while (!rvalid && waited < BUDGET) begin
      @(posedge aclk); #1; waited++;
    end
    if (!rvalid) begin
      fail_event("rvalid_timeout");
      return;
    end
    check_output("rd_latency", 32'(cyc - acc_cyc), 32'(RD_LAT));
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk); #1;
      check_output("hold_rvalid", 32'(rvalid), 32'd1);
      check_output("hold_arready", 32'(arready), 32'd0);
      check_output("hold_rdata", rdata, exp_data);
      check_output("hold_rid", 32'(rid), 32'(id));
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, input logic [1:0] exp_resp);
    int aw_cyc, w_cyc, last, waited;
    bit ok;
    ok = 1'b1;
    wr_q.push_back('{id: id, resp: exp_resp});
    fork
      begin
        int wt;
        repeat (aw_delay) begin @(posedge aclk); #1; end
        awid = id; awaddr = addr; awlen = 8'd0; awsize = size; awvalid = 1'b1;
        wt = 0;
        while (!awready && wt < BUDGET) begin @(posedge aclk); #1; wt++; end
        if (!awready) begin fail_event("aw_accept_timeout"); ok = 1'b0; end
        else begin @(posedge aclk); #1; end
        awvalid = 1'b0;
        aw_cyc = cyc;
      end
      begin
        int wt;
        repeat (w_delay) begin @(posedge aclk); #1; end
        wdata = data; wstrb = strb; wlast = 1'b1; wvalid = 1'b1;
        wt = 0;
        while (!wready && wt < BUDGET) begin @(posedge aclk); #1; wt++; end
        if (!wready) begin fail_event("w_accept_timeout"); ok = 1'b0; end
        else begin @(posedge aclk); #1; end
        wvalid = 1'b0;
        w_cyc = cyc;
      end
    join
    if (!ok) begin
      void'(wr_q.pop_back());
      return;
    end
    last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
    waited = 0;
    while (!bvalid && waited < BUDGET) begin @(posedge aclk); #1; waited++; end
    if (!bvalid) begin
      fail_event("bvalid_timeout");
      return;
    end
    check_output("wr_latency", 32'(cyc - last), 32'(WR_LAT));
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  // Monitor: every R or B handshake must match the oldest queued expectation.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (rvalid && rready) begin
        if (rd_q.size() == 0) fail_event("rd_unexpected");
        else begin
          mon_rd = rd_q.pop_front();
          check_output("rid", 32'(rid), 32'(mon_rd.id));
          check_output("rdata", rdata, mon_rd.data);
          check_output("rresp", 32'(rresp), 32'(mon_rd.resp));
          check_output("rlast", 32'(rlast), 32'd1);
        end
      end
      if (bvalid && bready) begin
        if (wr_q.size() == 0) fail_event("wr_unexpected");
        else begin
          mon_wr = wr_q.pop_front();
          check_output("bid", 32'(bid), 32'(mon_wr.id));
          check_output("bresp", 32'(bresp), 32'(mon_wr.resp));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0;
    arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    #2;
    check_idle_outputs("reset_state");
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Preload a few words, then reset again; RAM contents must survive it.
    do_write(4'd2, 32'h1c000010, 3'd2, 32'ha5a50010, 4'hf, 0, 0, RESP_OKAY);
    do_write(4'd2, 32'h1c000020, 3'd2, 32'h12345678, 4'hf, 1, 0, RESP_OKAY);
    do_write(4'd2, 32'h1c000030, 3'd2, 32'hcafef00d, 4'hf, 0, 1, RESP_OKAY);
    do_write(4'd2, 32'h1c000040, 3'd2, 32'h0badcafe, 4'hf, 0, 0, RESP_OKAY);
    pulse_reset("reset_after_preload");

    // Test 1: plain read of a preloaded word.
    do_read(4'd1, 32'h1c000010, 8'd0, 3'd2, 32'ha5a50010, RESP_OKAY, 0);

    // Test 2: AW first, W three cycles later, partial strobe.
    do_write(4'd3, 32'h1c000020, 3'd2, 32'hdeadbeef, 4'b0011, 0, 3, RESP_OKAY);
    do_read(4'd4, 32'h1c000020, 8'd0, 3'd2, 32'h1234beef, RESP_OKAY, 0);

    // Test 3: backpressure on R, then the next AR goes straight in.
    do_read(4'd5, 32'h1c000030, 8'd0, 3'd2, 32'hcafef00d, RESP_OKAY, 5);
    check_output("arready_after_r", 32'(arready), 32'd1);
    do_read(4'd6, 32'h1c000010, 8'd0, 3'd2, 32'ha5a50010, RESP_OKAY, 0);
    check_output("ar_wait_after_r", 32'(last_ar_wait), 32'd0);

    // Test 4: error responses.
    do_read(4'd6, 32'h00000000, 8'd0, 3'd2, 32'd0, RESP_DECERR, 0);
    do_read(4'd7, 32'h1c000010, 8'd3, 3'd2, 32'd0, RESP_SLVERR, 0);
    do_read(4'd7, 32'h1c000010, 8'd0, 3'd3, 32'd0, RESP_SLVERR, 0);
    do_write(4'd8, 32'h1c000030, 3'd3, 32'hffffffff, 4'hf, 0, 0, RESP_SLVERR);
    do_write(4'd9, 32'h20000030, 3'd2, 32'hffffffff, 4'hf, 0, 0, RESP_DECERR);
    do_read(4'd8, 32'h1c000030, 8'd0, 3'd2, 32'hcafef00d, RESP_OKAY, 0);

    // Test 5: write commit and read sample to the same word on the same edge.
    fork
      do_read(4'd7, 32'h1c000040, 8'd0, 3'd2, 32'h1122cafe, RESP_OKAY, 0);
      do_write(4'd8, 32'h1c000040, 3'd2, 32'h11223344, 4'b1100, 2, 2, RESP_OKAY);
    join
    do_read(4'd9, 32'h1c000040, 8'd0, 3'd2, 32'h1122cafe, RESP_OKAY, 0);
    do_write(4'd1, 32'h1c000024, 3'd2, 32'h0f0f0f0f, 4'hf, 0, 0, RESP_OKAY);
    do_read(4'd2, 32'h1c000024, 8'd0, 3'd2, 32'h0f0f0f0f, RESP_OKAY, 0);

    // Test 6a: reset while the read is counting down.
    arid = 4'd9; araddr = 32'h1c000010; arlen = 8'd0; arsize = 3'd2; arvalid = 1'b1;
    for (int i = 0; i < BUDGET && !arready; i++) begin @(posedge aclk); #1; end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    pulse_reset("reset_rd_wait");
    do_read(4'd10, 32'h1c000010, 8'd0, 3'd2, 32'ha5a50010, RESP_OKAY, 0);

    // Test 6b: reset with only AW collected.
    awid = 4'd10; awaddr = 32'h1c000050; awlen = 8'd0; awsize = 3'd2; awvalid = 1'b1;
    for (int i = 0; i < BUDGET && !awready; i++) begin @(posedge aclk); #1; end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    pulse_reset("reset_wr_collect");
    do_write(4'd11, 32'h1c000050, 3'd2, 32'h5555aaaa, 4'hf, 1, 0, RESP_OKAY);
    do_read(4'd12, 32'h1c000050, 8'd0, 3'd2, 32'h5555aaaa, RESP_OKAY, 0);

    repeat (3) @(posedge aclk);
    #1;
    check_output("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    check_output("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
